// File: rtl/fsm_run_loop_if.sv
// Start/abort request and status bundle for fsm_run_loop.
// The requester side (master) drives the i_* signals and observes the
// o_* status; the controller side (slave) does the opposite.
interface fsm_run_loop_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 i_run;
   logic [CNT_WIDTH-1:0] i_num_cnt;
   logic                 i_abort;
   logic                 o_idle;
   logic                 o_running;
   logic                 o_done;
   logic                 o_aborted;
   logic [CNT_WIDTH-1:0] o_cnt;

   modport master (
      output i_run, i_num_cnt, i_abort,
      input  o_idle, o_running, o_done, o_aborted, o_cnt
   );

   modport slave (
      input  i_run, i_num_cnt, i_abort,
      output o_idle, o_running, o_done, o_aborted, o_cnt
   );
endinterface

// File: rtl/fsm_run_loop.sv
// Run-loop controller: a start request loads a loop count, the FSM stays
// in RUN for that many cycles while counting, then shows DONE for a single
// cycle. A run can be cancelled with an abort, which wins over completion.
// With AUTO_REPEAT set, a start request seen in DONE chains straight into
// the next run without an IDLE cycle.
module fsm_run_loop #(
   parameter int CNT_WIDTH   = 8,
   parameter bit AUTO_REPEAT = 1'b0
) (
   input logic           clk,
   input logic           reset_n,
   fsm_run_loop_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic [CNT_WIDTH-1:0] num_r;
   logic [CNT_WIDTH-1:0] num_next;
   logic                 aborted;
   logic                 aborted_next;
   logic                 start;
   logic                 last;

   // A start is accepted in IDLE, and also in DONE when chaining runs.
   assign start = bus.i_run &&
                  ((state == IDLE) || (AUTO_REPEAT && (state == DONE)));

   // Final RUN cycle; num_r is at least 1 whenever the state is RUN, so the
   // subtraction never underflows there, and cnt never has to pass num_r-1.
   assign last = (cnt == (num_r - CNT_WIDTH'(1)));

   // State, progress counter, latched loop count and abort pulse register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         num_r   <= '0;
         aborted <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register updates from
         // the same pre-edge values, regardless of statement order.
         state   <= state_next;
         cnt     <= cnt_next;
         num_r   <= num_next;
         aborted <= aborted_next;
      end
   end

   // Next-state, counter and abort-pulse decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_next   = state;
      cnt_next     = cnt;
      num_next     = num_r;
      aborted_next = 1'b0;

      if (start) begin
         num_next   = bus.i_num_cnt;
         cnt_next   = '0;
         state_next = (bus.i_num_cnt == '0) ? DONE : RUN;
      end else begin
         unique case (state)
            IDLE: begin
               state_next = IDLE;
            end
            RUN: begin
               if (bus.i_abort) begin
                  // Abort beats the final count; cnt keeps its value.
                  state_next   = IDLE;
                  aborted_next = 1'b1;
               end else if (last) begin
                  state_next = DONE;
               end else begin
                  cnt_next = cnt + CNT_WIDTH'(1);
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Moore status decoded from registers only.
   assign bus.o_idle    = (state == IDLE);
   assign bus.o_running = (state == RUN);
   assign bus.o_done    = (state == DONE);
   assign bus.o_aborted = aborted;
   assign bus.o_cnt     = cnt;

endmodule

// File: tb/tb_fsm_run_loop.sv
// Scoreboard bench for fsm_run_loop. Two instances: an 8-bit, non-repeating
// one and a 4-bit, auto-repeating one. Stimulus pushes the expected end of
// each run (done or abort, final count, RUN length, IDLE gap) into a queue;
// a monitor per instance pops and compares whenever o_done or o_aborted fires.
module tb_fsm_run_loop;

   typedef struct {
      bit is_abort;
      int cnt;
      int run_len;
      int gap;       // IDLE cycles since the previous event, -1 = don't care
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ev_a;
   exp_t ev_b;
   int   run_a = 0, gap_a = 0;
   int   run_b = 0, gap_b = 0;

   always #5 clk = ~clk;

   fsm_run_loop_if #(.CNT_WIDTH(8)) bus_a ();
   fsm_run_loop_if #(.CNT_WIDTH(4)) bus_b ();

   fsm_run_loop #(.CNT_WIDTH(8), .AUTO_REPEAT(1'b0)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   fsm_run_loop #(.CNT_WIDTH(4), .AUTO_REPEAT(1'b1)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic compare_event(input string tag, input exp_t e, input logic done,
                                input logic aborted, input logic idle, input int cnt,
                                input int run_len, input int gap);
      check({tag, " o_aborted"}, int'(aborted), int'(e.is_abort));
      check({tag, " o_done"}, int'(done), int'(!e.is_abort));
      if (e.is_abort) check({tag, " idle with abort"}, int'(idle), 1);
      check({tag, " o_cnt at end"}, cnt, e.cnt);
      check({tag, " run cycles"}, run_len, e.run_len);
      if (e.gap >= 0) check({tag, " idle gap"}, gap, e.gap);
   endtask

   // Monitor for instance a.
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         run_a = 0;
         gap_a = 0;
      end else begin
         check("a one-hot", $countones({bus_a.o_idle, bus_a.o_running, bus_a.o_done}), 1);
         if (bus_a.o_running) run_a++;
         if (bus_a.o_idle) gap_a++;
         if (bus_a.o_done || bus_a.o_aborted) begin
            if (q_a.size() == 0) begin
               check("a unexpected event", 1, 0);
            end else begin
               ev_a = q_a.pop_front();
               compare_event("a", ev_a, bus_a.o_done, bus_a.o_aborted, bus_a.o_idle,
                             int'(bus_a.o_cnt), run_a, gap_a);
            end
            run_a = 0;
            gap_a = 0;
         end
      end
   end

   // Monitor for instance b.
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         run_b = 0;
         gap_b = 0;
      end else begin
         check("b one-hot", $countones({bus_b.o_idle, bus_b.o_running, bus_b.o_done}), 1);
         if (bus_b.o_running) run_b++;
         if (bus_b.o_idle) gap_b++;
         if (bus_b.o_done || bus_b.o_aborted) begin
            if (q_b.size() == 0) begin
               check("b unexpected event", 1, 0);
            end else begin
               ev_b = q_b.pop_front();
               compare_event("b", ev_b, bus_b.o_done, bus_b.o_aborted, bus_b.o_idle,
                             int'(bus_b.o_cnt), run_b, gap_b);
            end
            run_b = 0;
            gap_b = 0;
         end
      end
   end

   // Single-cycle start pulse; returns just after the accepting edge.
   task automatic start_a(input int n);
      bus_a.i_run     = 1'b1;
      bus_a.i_num_cnt = 8'(n);
      @(posedge clk);
      #1 bus_a.i_run = 1'b0;
   endtask

   task automatic start_b(input int n);
      bus_b.i_run     = 1'b1;
      bus_b.i_num_cnt = 4'(n);
      @(posedge clk);
      #1 bus_b.i_run = 1'b0;
   endtask

   task automatic drain_a();
      for (int i = 0; i < 300 && q_a.size() != 0; i++) @(negedge clk);
      if (q_a.size() != 0) begin
         check("a events outstanding after timeout", q_a.size(), 0);
         q_a.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic drain_b();
      for (int i = 0; i < 300 && q_b.size() != 0; i++) @(negedge clk);
      if (q_b.size() != 0) begin
         check("b events outstanding after timeout", q_b.size(), 0);
         q_b.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " a o_idle"},    int'(bus_a.o_idle), 1);
      check({tag, " a o_running"}, int'(bus_a.o_running), 0);
      check({tag, " a o_done"},    int'(bus_a.o_done), 0);
      check({tag, " a o_aborted"}, int'(bus_a.o_aborted), 0);
      check({tag, " a o_cnt"},     int'(bus_a.o_cnt), 0);
      check({tag, " b o_idle"},    int'(bus_b.o_idle), 1);
      check({tag, " b o_cnt"},     int'(bus_b.o_cnt), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n         = 1'b1;
      bus_a.i_run     = 1'b0;
      bus_a.i_num_cnt = '0;
      bus_a.i_abort   = 1'b0;
      bus_b.i_run     = 1'b0;
      bus_b.i_num_cnt = '0;
      bus_b.i_abort   = 1'b0;

      // Reset acts without a clock edge.
      #1 reset_n = 1'b0;
      #1 check_reset_state("reset");

      // Release between edges; start is accepted at the very first edge.
      #10 reset_n = 1'b1;
      q_a.push_back('{1'b0, 4, 5, -1});
      start_a(5);
      drain_a();
      check("a idle after run of 5", int'(bus_a.o_idle), 1);
      check("a o_cnt held in idle", int'(bus_a.o_cnt), 4);

      // Zero-length run: straight to DONE, never RUN.
      q_a.push_back('{1'b0, 0, 0, -1});
      start_a(0);
      drain_a();

      // Abort mid-run at o_cnt=3.
      q_a.push_back('{1'b1, 3, 4, -1});
      start_a(10);
      repeat (3) @(posedge clk);
      #1 bus_a.i_abort = 1'b1;
      @(posedge clk);
      #1 bus_a.i_abort = 1'b0;
      drain_a();

      // Abort coinciding with the final count (o_cnt=9 of 10).
      q_a.push_back('{1'b1, 9, 10, -1});
      start_a(10);
      repeat (9) @(posedge clk);
      #1 bus_a.i_abort = 1'b1;
      @(posedge clk);
      #1 bus_a.i_abort = 1'b0;
      drain_a();

      // Abort while idle does nothing.
      bus_a.i_abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("a no abort pulse in idle", int'(bus_a.o_aborted), 0);
      end
      bus_a.i_abort = 1'b0;

      // Held start without auto-repeat: one IDLE cycle between runs.
      q_a.push_back('{1'b0, 2, 3, -1});
      q_a.push_back('{1'b0, 2, 3, 1});
      q_a.push_back('{1'b0, 2, 3, 1});
      bus_a.i_run     = 1'b1;
      bus_a.i_num_cnt = 8'd3;
      repeat (11) @(posedge clk);
      #1 bus_a.i_run = 1'b0;
      drain_a();

      // Reset mid-run at o_cnt=2: abandoned, no event, then a clean restart.
      start_a(6);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_state("mid-run reset");
      #9 reset_n = 1'b1;
      q_a.push_back('{1'b0, 1, 2, -1});
      start_a(2);
      drain_a();

      // Auto-repeat with held start: DONE every 4 cycles, no IDLE in between.
      q_b.push_back('{1'b0, 2, 3, -1});
      q_b.push_back('{1'b0, 2, 3, 0});
      q_b.push_back('{1'b0, 2, 3, 0});
      bus_b.i_run     = 1'b1;
      bus_b.i_num_cnt = 4'd3;
      repeat (9) @(posedge clk);
      #1 bus_b.i_run = 1'b0;
      drain_b();

      // Full 4-bit count with start pulses during RUN that must be ignored.
      q_b.push_back('{1'b0, 14, 15, -1});
      start_b(15);
      repeat (4) @(posedge clk);
      #1 begin bus_b.i_run = 1'b1; bus_b.i_num_cnt = 4'd3; end
      @(posedge clk);
      #1 bus_b.i_run = 1'b0;
      repeat (3) @(posedge clk);
      #1 begin bus_b.i_run = 1'b1; bus_b.i_num_cnt = 4'd1; end
      @(posedge clk);
      #1 bus_b.i_run = 1'b0;
      drain_b();
      check("b idle after full count", int'(bus_b.o_idle), 1);
      check("b o_cnt held at 14", int'(bus_b.o_cnt), 14);

      // Zero-length run on the auto-repeat instance.
      q_b.push_back('{1'b0, 0, 0, -1});
      start_b(0);
      drain_b();

      // Abort coinciding with the final count (o_cnt=2 of 3).
      q_b.push_back('{1'b1, 2, 3, -1});
      start_b(3);
      repeat (2) @(posedge clk);
      #1 bus_b.i_abort = 1'b1;
      @(posedge clk);
      #1 bus_b.i_abort = 1'b0;
      drain_b();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fsm_run_loop.md
FSM_RUN_LOOP -- requirements
Module: fsm_run_loop

Interface
REQ-001 Parameter CNT_WIDTH, default 8: width of the loop-count input and the progress counter.
REQ-002 Parameter AUTO_REPEAT, default 0: 1 = restart a new run directly from DONE when i_run is high in DONE; 0 = always return to IDLE.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_run  input  1  start request; sampled in IDLE, and in DONE when AUTO_REPEAT=1.
REQ-006 i_num_cnt  input  CNT_WIDTH  number of RUN cycles; captured together with an accepted i_run.
REQ-007 i_abort  input  1  cancel the active run.
REQ-008 o_idle  output  1  high while the state is IDLE.
REQ-009 o_running  output  1  high while the state is RUN.
REQ-010 o_done  output  1  high for exactly the one cycle the state is DONE.
REQ-011 o_aborted  output  1  one-cycle pulse following an accepted abort.
REQ-012 o_cnt  output  CNT_WIDTH  current RUN progress count.

Function
REQ-013 The FSM shall have three states, IDLE, RUN and DONE, held in a state register.
REQ-014 All outputs except o_aborted shall be Moore outputs decoded from the state register and counter registers only.
REQ-015 In IDLE, i_run=1 at a rising edge shall:
- latch i_num_cnt into an internal register num_r;
- clear o_cnt to 0;
- move to RUN, or to DONE directly if i_num_cnt=0.
REQ-016 In RUN, o_cnt shall increment by 1 each cycle.
REQ-017 When o_cnt = num_r-1 and no abort is present, the next state shall be DONE, with o_cnt holding num_r-1.
REQ-018 Latency: i_run sampled at edge k with N>=1 gives RUN for edges k..k+N-1 and o_done high for exactly the cycle after edge k+N.
REQ-019 Latency for N=0: o_done shall be high for the cycle after edge k, and o_running shall never assert.
REQ-020 DONE shall last exactly one cycle. The next state is IDLE, except:
- AUTO_REPEAT=1 with i_run=1 in DONE re-latches i_num_cnt, clears o_cnt and enters RUN (or DONE if 0), with no IDLE cycle.
REQ-021 i_run while in RUN shall be ignored; it is neither queued nor does it restart the counter.
REQ-022 i_abort=1 in RUN shall:
- move the state to IDLE at the next edge;
- pulse o_aborted for that one cycle;
- suppress o_done for that run.
REQ-023 If i_abort and the final count (o_cnt = num_r-1) coincide, abort shall win: no DONE, o_aborted pulses.
REQ-024 i_abort in IDLE or DONE shall have no effect and shall not pulse o_aborted.
REQ-025 num_r=2^CNT_WIDTH-1 shall run the full count without wrap, and o_cnt shall never wrap.
REQ-026 o_cnt shall hold its last value in IDLE until the next accepted start.
REQ-027 Exactly one of o_idle, o_running, o_done shall be high in every cycle.

Reset
REQ-028 reset_n=0 shall immediately, without a clock edge, force:
- state to IDLE, with o_idle=1;
- o_running=0, o_done=0, o_aborted=0;
- o_cnt=0 and num_r=0.
REQ-029 Reset asserted mid-RUN or in DONE shall abandon the run, with no o_done and no o_aborted pulse afterwards.
REQ-030 After reset_n rises, the FSM shall accept i_run at the first rising edge.

Verification
REQ-031 Reset then i_run=1 for one cycle with i_num_cnt=5 -> o_running high 5 cycles (o_cnt 0..4), o_done high 1 cycle, then o_idle=1 with o_cnt=4.
REQ-032 i_num_cnt=0 with an i_run pulse -> o_done high the next cycle, o_running never high.
REQ-033 i_num_cnt=10, i_abort pulsed when o_cnt=3 -> o_aborted 1 cycle, o_idle next, no o_done; repeat with abort at o_cnt=9 -> same result.
REQ-034 AUTO_REPEAT=1, i_num_cnt=3, i_run held high -> o_done pulses every 4 cycles, no o_idle cycle between runs; AUTO_REPEAT=0 -> one IDLE cycle between runs.
REQ-035 reset_n pulsed low mid-RUN at o_cnt=2 (i_num_cnt=6) -> asynchronous return to o_idle=1 and o_cnt=0, no o_done, and a new run starts normally afterwards.
REQ-036 CNT_WIDTH=4, i_num_cnt=15 -> exactly 15 RUN cycles, o_cnt ends at 14, no wrap; i_run pulses during RUN are ignored.
